// File: rtl/constraint_vec_checker_pkg.sv
// constraint_pkg: shared constraint mode enum, default sizes and saturating increment
// Ports: none (package)
package constraint_pkg;
  typedef enum logic {CM_NEQ = 1'b0, CM_EQ = 1'b1} cmode_t;
  localparam int DEF_W = 16;
  localparam int DEF_N = 4;
  localparam int DEF_CNT_W = 16;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (v >= m) ? m : v + 32'd1;
  endfunction
endpackage

// File: rtl/constraint_vec_checker_if.sv
// constraint_vec_checker_if: config, stream, clear and statistics bundle of the checker
// Ports: cfg_*, in_* (valid/ready/data), out_* (valid/ready/sat/mask), clr, pass/fail counters, ff_*
interface constraint_vec_checker_if import constraint_pkg::*; #(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) ();
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [W-1:0] cfg_const;
  logic cfg_mode;
  logic in_valid;
  logic in_ready;
  logic [N*W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic out_sat;
  logic [N-1:0] out_mask;
  logic clr;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic ff_valid;
  logic [N-1:0] ff_mask;
  modport slave (
    input cfg_we, cfg_idx, cfg_const, cfg_mode, in_valid, in_data, out_ready, clr,
    output in_ready, out_valid, out_sat, out_mask, pass_cnt, fail_cnt, ff_valid, ff_mask
  );
  modport master (
    output cfg_we, cfg_idx, cfg_const, cfg_mode, in_valid, in_data, out_ready, clr,
    input in_ready, out_valid, out_sat, out_mask, pass_cnt, fail_cnt, ff_valid, ff_mask
  );
endinterface

// File: rtl/constraint_vec_checker_lane.sv
// constraint_lane: one channel's constant/mode registers and its combinational pass test
// Ports: clk, rst, i_we/i_const/i_mode (config write), i_data (channel data), o_pass
module constraint_lane import constraint_pkg::*; #(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_we,
  input  logic [W-1:0] i_const,
  input  cmode_t       i_mode,
  input  logic [W-1:0] i_data,
  output logic         o_pass
);
  logic [W-1:0] r_const;
  cmode_t r_mode;
  logic [W-1:0] w_diff;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_const <= '0;
      r_mode <= CM_NEQ;
    end else if (i_we) begin
      r_const <= i_const;
      r_mode <= i_mode;
    end
  assign w_diff = i_data - r_const;
  assign o_pass = (r_mode == CM_EQ) ? (w_diff == '0) : (w_diff != '0);
endmodule

// File: rtl/constraint_vec_checker.sv
// constraint_vec_checker: two-stage N-channel constraint checker with pass/fail stats and first-fail capture
// Ports: clk, rst (async, active high), bus (slave modport of constraint_vec_checker_if)
module constraint_vec_checker import constraint_pkg::*; #(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  constraint_vec_checker_if.slave bus
);
  logic [N-1:0] w_pass;
  logic [N-1:0] r_s1_pass;
  logic [N-1:0] r_mask;
  logic [N-1:0] r_ff_mask;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic r_s1_valid;
  logic r_out_valid;
  logic r_sat;
  logic r_ff_valid;
  logic w_adv1;
  logic w_adv2;
  logic w_acc;
  logic w_hs;
  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_lane
      constraint_lane #(.W(W)) u_lane (
        .clk(clk),
        .rst(rst),
        .i_we(bus.cfg_we && (32'(bus.cfg_idx) == k)),
        .i_const(bus.cfg_const),
        .i_mode(cmode_t'(bus.cfg_mode)),
        .i_data(bus.in_data[k*W +: W]),
        .o_pass(w_pass[k])
      );
    end
  endgenerate
  // ready depends only on registered valids and out_ready, never on in_valid
  assign w_adv2 = !r_out_valid || bus.out_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;
  assign w_acc = bus.in_valid && w_adv1;
  assign w_hs = r_out_valid && bus.out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pass <= '0;
      r_out_valid <= 1'b0;
      r_mask <= '0;
      r_sat <= 1'b0;
    end else begin
      if (w_adv1) r_s1_valid <= bus.in_valid;
      if (w_acc) r_s1_pass <= w_pass;
      if (w_adv2) r_out_valid <= r_s1_valid;
      if (w_adv2 && r_s1_valid) begin
        r_mask <= r_s1_pass;
        r_sat <= &r_s1_pass;
      end
    end
  // clr has priority so a beat handshaking on the clear edge is dropped from the stats
  always_ff @(posedge clk or posedge rst)
    if (rst || bus.clr) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_ff_valid <= 1'b0;
      r_ff_mask <= '0;
    end else if (w_hs) begin
      if (r_sat) r_pass_cnt <= CNT_W'(sat_inc(32'(r_pass_cnt), CNT_W));
      else begin
        r_fail_cnt <= CNT_W'(sat_inc(32'(r_fail_cnt), CNT_W));
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_mask <= r_mask;
        end
      end
    end
  assign bus.in_ready = w_adv1;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sat = r_sat;
  assign bus.out_mask = r_mask;
  assign bus.pass_cnt = r_pass_cnt;
  assign bus.fail_cnt = r_fail_cnt;
  assign bus.ff_valid = r_ff_valid;
  assign bus.ff_mask = r_ff_mask;
endmodule

// File: tb/tb_constraint_vec_checker.sv
// tb_constraint_vec_checker: table vectors, corner sequences and random traffic against a scoreboard model
module tb_constraint_vec_checker;
  localparam int W = 16;
  localparam int N = 4;
  localparam int CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;
  typedef struct {
    logic [N*W-1:0] data;
    logic [N-1:0] mask;
    logic sat;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_fail = 0;
  int m_cst[N];
  int m_mode[N];
  int m_pass, m_fail;
  logic m_ffv;
  logic [N-1:0] m_ffm;
  logic [N:0] q[$];
  logic prev_stall;
  logic [N:0] prev_out;
  vec_t tbl[6];
  constraint_vec_checker_if #(.W(W), .N(N), .CNT_W(CNT_W)) bus ();
  constraint_vec_checker #(.W(W), .N(N), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [N:0] model_eval(input logic [N*W-1:0] d);
    logic [N-1:0] m;
    int diff;
    for (int i = 0; i < N; i++) begin
      diff = ((int'(d[i*W +: W]) - m_cst[i]) % 65536 + 65536) % 65536;
      m[i] = (m_mode[i] != 0) ? (diff == 0) : (diff != 0);
    end
    return {&m, m};
  endfunction
  // scoreboard: sees each edge's events half a cycle early, compares stats from the previous edge
  always @(negedge clk) begin
    logic [N:0] e;
    logic hs;
    if (rst) begin
      q.delete();
      m_pass = 0;
      m_fail = 0;
      m_ffv = 1'b0;
      m_ffm = '0;
      prev_stall = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_cst[i] = 0;
        m_mode[i] = 0;
      end
    end else begin
      check("pass_cnt", 64'(bus.pass_cnt), 64'(m_pass));
      check("fail_cnt", 64'(bus.fail_cnt), 64'(m_fail));
      check("ff_valid", 64'(bus.ff_valid), 64'(m_ffv));
      check("ff_mask", 64'(bus.ff_mask), 64'(m_ffm));
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2 || bus.out_ready));
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_out", 64'({bus.out_sat, bus.out_mask}), 64'(prev_out));
      end
      hs = bus.out_valid && bus.out_ready;
      e = {bus.out_sat, bus.out_mask};
      if (hs) begin
        if (q.size() == 0) check("spurious_out", 64'(bus.out_valid), 64'd0);
        else begin
          e = q.pop_front();
          check("out_mask", 64'(bus.out_mask), 64'(e[N-1:0]));
          check("out_sat", 64'(bus.out_sat), 64'(e[N]));
        end
      end
      if (bus.clr) begin
        m_pass = 0;
        m_fail = 0;
        m_ffv = 1'b0;
        m_ffm = '0;
      end else if (hs) begin
        if (e[N]) m_pass = (m_pass < MAXC) ? m_pass + 1 : MAXC;
        else begin
          m_fail = (m_fail < MAXC) ? m_fail + 1 : MAXC;
          if (!m_ffv) begin
            m_ffv = 1'b1;
            m_ffm = e[N-1:0];
          end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model_eval(bus.in_data));
      if (bus.cfg_we && int'(bus.cfg_idx) < N) begin
        m_cst[bus.cfg_idx] = int'(bus.cfg_const);
        m_mode[bus.cfg_idx] = int'(bus.cfg_mode);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out = {bus.out_sat, bus.out_mask};
    end
  end
  task automatic send(input logic [N*W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    check("accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.out_valid) break;
    end
    check("drain", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int idx, input logic [W-1:0] c, input logic md);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = 2'(idx);
    bus.cfg_const = c;
    bus.cfg_mode = md;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask
  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
  endtask
  task automatic apply_vec(input vec_t v);
    send(v.data);
    check("lat_e0_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_e1_valid", 64'(bus.out_valid), 64'd1);
    check("vec_mask", 64'(bus.out_mask), 64'(v.mask));
    check("vec_sat", 64'(bus.out_sat), 64'(v.sat));
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [N-1:0] sm;
    logic [N*W-1:0] d;
    tbl[0] = '{64'h0000_0000_0000_0000, 4'b0000, 1'b0};
    tbl[1] = '{64'h0001_0001_0001_0001, 4'b1111, 1'b1};
    tbl[2] = '{64'h0001_1bde_0001_ffff, 4'b1011, 1'b0};
    tbl[3] = '{64'h0001_1bdf_0001_0000, 4'b1110, 1'b0};
    tbl[4] = '{64'h0007_1bdf_0005_ffff, 4'b1111, 1'b1};
    tbl[5] = '{64'h0000_1bdf_0000_ffff, 4'b0101, 1'b0};
    rst = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_const = '0;
    bus.cfg_mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    check("rst_out_mask", 64'(bus.out_mask), 64'd0);
    check("rst_pass_cnt", 64'(bus.pass_cnt), 64'd0);
    check("rst_fail_cnt", 64'(bus.fail_cnt), 64'd0);
    check("rst_ff_valid", 64'(bus.ff_valid), 64'd0);
    check("rst_ff_mask", 64'(bus.ff_mask), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 2; i++) apply_vec(tbl[i]);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cfg(2, 16'h1bde, 1'b0);
    cfg(0, 16'hffff, 1'b1);
    apply_vec(tbl[2]);
    check("first_fail_cnt", 64'(bus.fail_cnt), 64'd1);
    check("first_ff_valid", 64'(bus.ff_valid), 64'd1);
    check("first_ff_mask", 64'(bus.ff_mask), 64'b1011);
    for (int i = 3; i < 6; i++) apply_vec(tbl[i]);
    check("ff_kept", 64'(bus.ff_mask), 64'b1011);
    pulse_clr();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) send({16'(i), 16'h1bdf, 16'(i), 16'hffff});
    bus.in_valid = 1'b1;
    bus.in_data = {16'd2, 16'h1bdf, 16'd2, 16'hffff};
    @(negedge clk);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    sm = bus.out_mask;
    repeat (2) begin
      @(negedge clk);
      check("bp_stable", 64'(bus.out_mask), 64'(sm));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 2; i < 5; i++) send({16'(i), 16'h1bdf, 16'(i), 16'hffff});
    drain();
    check("bp_total", 64'(bus.pass_cnt) + 64'(bus.fail_cnt), 64'd5);
    pulse_clr();
    repeat (20) send(64'h0001_1bdf_0001_ffff);
    drain();
    check("sat_pass_cnt", 64'(bus.pass_cnt), 64'd15);
    send(64'h0001_1bdf_0001_ffff);
    @(posedge clk);
    #1;
    check("clr_hs_valid", 64'(bus.out_valid), 64'd1);
    bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    check("clr_hs_pass", 64'(bus.pass_cnt), 64'd0);
    check("clr_hs_fail", 64'(bus.fail_cnt), 64'd0);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = 2'd1;
    bus.cfg_const = 16'h0005;
    bus.cfg_mode = 1'b0;
    send(64'h0001_1bdf_0005_ffff);
    bus.cfg_we = 1'b0;
    send(64'h0001_1bdf_0005_ffff);
    check("cfg_old_mask", 64'(bus.out_mask), 64'b1111);
    @(posedge clk);
    #1;
    check("cfg_new_mask", 64'(bus.out_mask), 64'b1101);
    check("cfg_new_sat", 64'(bus.out_sat), 64'd0);
    drain();
    pulse_clr();
    bus.out_ready = 1'b0;
    send(64'h0001_1bdf_0001_ffff);
    send(64'h0001_1bdf_0001_ffff);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_pass_cnt", 64'(bus.pass_cnt), 64'd0);
    check("arst_fail_cnt", 64'(bus.fail_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_discarded", 64'(bus.out_valid), 64'd0);
    repeat (1500) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: d[i*W +: W] = W'(m_cst[i]);
          1: d[i*W +: W] = W'(m_cst[i] + 1);
          2: d[i*W +: W] = W'(m_cst[i] - 1);
          default: d[i*W +: W] = W'($urandom);
        endcase
      end
      bus.in_data = d;
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.clr = ($urandom_range(0, 49) == 0);
      bus.cfg_we = ($urandom_range(0, 7) == 0);
      bus.cfg_idx = 2'($urandom_range(0, N - 1));
      bus.cfg_const = ($urandom_range(0, 1) == 0) ? 16'hffff : W'($urandom_range(0, 3));
      bus.cfg_mode = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b0;
    bus.clr = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
